// File: rtl/branch_predictor_bht_pkg.sv
// Shared helpers for the branch predictor.
// Holds the counter constants, the PC index/tag extraction and the saturating
// counter step. Widths are passed in as arguments so that every parameterisation
// of the predictor can share one package.
package branch_predictor_bht_pkg;

    // Weakly-not-taken: 2^(ctr_w-1)-1
    function automatic logic [31:0] ctr_weak_nt(input int unsigned ctr_w);
        return (32'd1 << (ctr_w - 1)) - 32'd1;
    endfunction

    // Weakly-taken: 2^(ctr_w-1); also the lowest value whose MSB is set
    function automatic logic [31:0] ctr_weak_t(input int unsigned ctr_w);
        return 32'd1 << (ctr_w - 1);
    endfunction

    function automatic logic [31:0] ctr_max(input int unsigned ctr_w);
        return (32'd1 << ctr_w) - 32'd1;
    endfunction

    // Table index: pc[idx_w+1:2]
    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // BTB tag: pc[idx_w+tag_w+1 : idx_w+2]
    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned idx_w,
                                           input int unsigned tag_w);
        return (pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1);
    endfunction

    // One saturating step up or down, clamped to [0, 2^ctr_w-1]
    function automatic logic [31:0] sat_step(input logic [31:0] v, input logic up,
                                             input int unsigned ctr_w);
        if (up)
            return (v == ctr_max(ctr_w)) ? v : v + 32'd1;
        else
            return (v == 32'd0) ? v : v - 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_bht_sat_counter_table.sv
// Pattern history table: ENTRIES saturating counters of CTR_W bits in flops.
// Ports:
//   clk, reset     clock, synchronous active-high reset (all counters -> weakly-not-taken)
//   rd_idx/rd_ctr  combinational read port
//   upd_valid      apply an update at upd_idx this edge
//   upd_taken      step direction
//   upd_set_weak   load weakly-taken instead of stepping (taken branch that missed the BTB)
module sat_counter_table
    import branch_predictor_bht_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0] rd_ctr,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic             upd_set_weak
);

    logic [CTR_W-1:0] ctr [ENTRIES];
    logic [CTR_W-1:0] next_ctr;

    assign rd_ctr = ctr[rd_idx];

    always_comb begin
        next_ctr = ctr[upd_idx];
        if (upd_set_weak)
            next_ctr = CTR_W'(ctr_weak_t(CTR_W));
        else
            next_ctr = CTR_W'(sat_step(32'(ctr[upd_idx]), upd_taken, CTR_W));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr[i] <= CTR_W'(ctr_weak_nt(CTR_W));
        end else if (upd_valid) begin
            ctr[upd_idx] <= next_ctr;
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Branch predictor: bimodal or gshare direction table plus a tagged BTB.
// Lookup is combinational from the IF PC; updates come from ID resolution.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   lookup_valid, lookup_pc     IF fetch
//   stall                       freezes speculative history
//   pred_hit/taken/target/hist  prediction for lookup_pc (pred_hist travels with the insn)
//   upd_valid, upd_pc, upd_taken, upd_target, upd_hist, upd_mispredict   ID resolution
module branch_predictor_bht
    import branch_predictor_bht_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int TAG_W   = 8,
    parameter int GSHARE  = 0,
    parameter int HIST_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lookup_valid,
    input  logic [31:0]       lookup_pc,
    input  logic              stall,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    output logic [HIST_W-1:0] pred_hist,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic [HIST_W-1:0] upd_hist,
    input  logic              upd_mispredict
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]   btb_tag    [ENTRIES];
    logic [31:0]        btb_target [ENTRIES];
    logic [HIST_W-1:0]  ghr;

    logic [IDX_W-1:0]   lk_bidx, lk_pidx, up_bidx, up_pidx;
    logic [TAG_W-1:0]   lk_tag, up_tag;
    logic [CTR_W-1:0]   lk_ctr;
    logic               up_hit;

    assign lk_bidx = IDX_W'(pc_index(lookup_pc, IDX_W));
    assign lk_tag  = TAG_W'(pc_tag(lookup_pc, IDX_W, TAG_W));
    assign up_bidx = IDX_W'(pc_index(upd_pc, IDX_W));
    assign up_tag  = TAG_W'(pc_tag(upd_pc, IDX_W, TAG_W));

    // Update indexes with the history the branch was predicted under, not the live ghr
    assign lk_pidx = (GSHARE != 0) ? (lk_bidx ^ IDX_W'(ghr))      : lk_bidx;
    assign up_pidx = (GSHARE != 0) ? (up_bidx ^ IDX_W'(upd_hist)) : up_bidx;

    assign up_hit  = btb_valid[up_bidx] && (btb_tag[up_bidx] == up_tag);

    sat_counter_table #(
        .ENTRIES (ENTRIES),
        .CTR_W   (CTR_W)
    ) u_pht (
        .clk          (clk),
        .reset        (reset),
        .rd_idx       (lk_pidx),
        .rd_ctr       (lk_ctr),
        .upd_valid    (upd_valid),
        .upd_idx      (up_pidx),
        .upd_taken    (upd_taken),
        .upd_set_weak (upd_taken && !up_hit)
    );

    assign pred_hit    = btb_valid[lk_bidx] && (btb_tag[lk_bidx] == lk_tag);
    // Counter >= 2^(CTR_W-1) is exactly "MSB set"
    assign pred_taken  = pred_hit && (lk_ctr >= CTR_W'(ctr_weak_t(CTR_W)));
    assign pred_target = pred_taken ? btb_target[lk_bidx] : lookup_pc + 32'd4;
    assign pred_hist   = ghr;

    always_ff @(posedge clk) begin
        if (reset)
            btb_valid <= '0;
        else if (upd_valid && upd_taken)
            btb_valid[up_bidx] <= 1'b1;
    end

    // Tag/target need no reset; they are qualified by btb_valid
    always_ff @(posedge clk) begin
        if (!reset && upd_valid && upd_taken) begin
            btb_tag[up_bidx]    <= up_tag;
            btb_target[up_bidx] <= upd_target;
        end
    end

    // Repair from ID beats speculative shift from IF; truncation drops the oldest bit
    always_ff @(posedge clk) begin
        if (reset)
            ghr <= '0;
        else if (upd_valid && upd_mispredict)
            ghr <= HIST_W'({upd_hist, upd_taken});
        else if (lookup_valid && !stall && pred_hit)
            ghr <= HIST_W'({ghr, pred_taken});
    end

endmodule
